datapath_bus_core: RTL
======================

# datapath_bus_core

Parametrised successor to the fixed 16-bit datapath top: a WIDTH-bit, NREG-entry register file with A/B/S bus muxing, NZVC PSW register and MAR/MDR. Memory access goes through a req/ack handshake FSM with wait states, instead of single-cycle MDR strobes. The block sits between the controller and external ALU/shifter/multiplier units, which consume the A/B buses and return results on `s_in`.

## Interface
- `WIDTH`, 16: data/address width, ≥8.
- `NREG`, 8: number of general registers, power of two, ≥2.
- `PSW_IDX`, 5: register index that shadows the PSW, must be < NREG.
- `TIMEOUT`, 15: cycles in REQ without ack before abort, 1..255.
- `CLK` in 1: single clock, rising edge.
- `CLR` in 1: asynchronous, active-low reset.
- `a_en` in 1: drive the selected register onto the A bus.
- `a_sel` in log2(NREG): A-bus register index.
- `a_mdr` in 1: drive the MDR onto the A bus.
- `b_en` in 1: drive B0 onto the B bus.
- `s_in` in WIDTH: S-bus result from the external units.
- `reg_we` in 1: write the S bus into register `reg_wsel`.
- `reg_wsel` in log2(NREG): write index.
- `b0_we` in 1: load B0 from the S bus.
- `mar_we` in 1: load MAR from the S bus.
- `mdr_we` in 1: load MDR from the S bus.
- `flag_upd` in 4: per-flag update mask, NZVC order.
- `flag_val` in 4: new flag values.
- `psw_load` in 1: load NZVC from `s_in[3:0]`.
- `mem_rd` in 1: start a memory read pulse.
- `mem_wr` in 1: start a memory write pulse.
- `a_bus` out WIDTH: A bus.
- `b_bus` out WIDTH: B bus.
- `psw` out 4: NZVC.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write qualifier.
- `mem_addr` out WIDTH: equals MAR.
- `mem_wdata` out WIDTH: equals MDR.
- `mem_rdata` in WIDTH: read data.
- `mem_ack` in 1: memory acknowledge.
- `busy` out 1: FSM not IDLE.
- `done` out 1: one-cycle transaction-complete pulse.
- `err` out 1: one-cycle pulse on a rejected command or a timeout.

## Operation
- **A bus (AND-OR):**
  - `a_bus` = (`a_en` ? reg[`a_sel`] : 0) | (`a_mdr` ? MDR : 0).
  - Both enables high gives the OR of the two sources; that is legal and not flagged.
- **B bus:** `b_bus` = `b_en` ? B0 : 0.
- **Register PSW_IDX:** a `reg_we` to PSW_IDX writes zero-extended `psw` (current value, pre-edge), not `s_in`. Every other index takes `s_in`.
- **PSW update:**
  - `psw_load` has priority over `flag_upd`.
  - Otherwise, each bit i with `flag_upd[i]`=1 takes `flag_val[i]`; the other bits hold.
- **MDR load priority:** read-data capture > `mdr_we`. `mdr_we` and `mar_we` are ignored while `busy`.
- **FSM states:** IDLE, REQ, DONE.
- **IDLE:**
  - `mem_rd` xor `mem_wr` → REQ, latching direction into `mem_we`.
  - Both high → `err` pulse, stay in IDLE.
- **REQ:**
  - `mem_req`=1, address/data held stable.
  - On `mem_ack`, a read captures `mem_rdata` into MDR, then go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Commands while busy:** ignored and pulse `err`.

## Timing
- **Reset values:** all registers, MAR, MDR, B0 and `psw` = 0. FSM in IDLE. `mem_req`, `mem_we`, `busy`, `done`, `err` = 0.
- **Reset mid-transaction:** `mem_req` drops asynchronously and no capture occurs.
- **Bus outputs:** `a_bus` and `b_bus` are combinational.
- **Register, B0, MAR, MDR and PSW writes:** visible the cycle after the edge.
- **Transaction latency:**
  - `mem_rd` sampled at edge t → `mem_req` high in cycle t+1.
  - `mem_ack` seen at edge k → MDR valid and `done`=1 in cycle k+1, IDLE in cycle k+2.
  - Minimum: 3 cycles from command to next accepted command (ack in first REQ cycle).
- **Late ack:** `mem_ack` outside REQ is ignored.
- **Same-edge `reg_we` + `a_sel` on one index:** `a_bus` shows the old value this cycle.

## Configuration
- **`DATAPATH_BUS_TIMEOUT_EN` defined:**
  - An 8-bit counter runs in REQ. After TIMEOUT cycles without ack, go to IDLE with `err`=1 for one cycle.
  - MDR is unchanged and `done` stays 0.
  - The counter clears on entry to REQ.
- **Undefined:** no counter; REQ waits indefinitely.

## Structure
- **Package `dp_pkg`:** FSM state typedef `dp_mem_state_t`; flag index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_V`=1, `FLAG_C`=0.
- **Sub-module `dp_mem_fsm`:** the handshake FSM plus timeout counter. It outputs `mem_req`, `mem_we`, `busy`, `done`, `err` and the capture strobe; the top holds storage and buses.

## Test plan
- Reset, then `s_in`=16'hA5A5 with `reg_we`, `reg_wsel`=2; next cycle `a_en`, `a_sel`=2 → `a_bus`=16'hA5A5, `b_bus`=0.
- `flag_upd`=4'b1001, `flag_val`=4'b1111 from `psw`=0 → `psw`=4'b1001. Then `reg_we` to PSW_IDX with `s_in`=16'hFFFF → reg5=16'h0009.
- MAR=16'h0040, `mem_rd`, `mem_rdata`=16'h1234, ack after 3 REQ cycles → MDR=16'h1234, `done` pulse once, `busy` for 5 cycles.
- MDR=16'hBEEF, `mem_wr`, ack in first REQ cycle → `mem_we`=1, `mem_wdata`=16'hBEEF. A `mem_rd` issued during REQ gives an `err` pulse with no second transaction.
- `mem_rd`+`mem_wr` together in IDLE → `err`=1, `mem_req` stays 0.
- With the macro defined, TIMEOUT=4, no ack → `mem_req` high for 4 cycles, then `err`; MDR unchanged. Also assert `CLR` low mid-REQ → `mem_req`=0 immediately.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types and constants for the bus-oriented datapath.
// The optional REQ timeout is enabled by DATAPATH_BUS_TIMEOUT_EN (see dp_mem_fsm).
package dp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } dp_mem_state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/dp_mem_fsm.sv
// Memory req/ack handshake controller: one outstanding transaction, err/done pulses.
// Define DATAPATH_BUS_TIMEOUT_EN to abort a request after TIMEOUT cycles without ack.
module dp_mem_fsm
   import dp_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic CLK,
   input  logic CLR,
   input  logic mem_rd_i,
   input  logic mem_wr_i,
   input  logic mem_ack_i,
   output logic mem_req_o,
   output logic mem_we_o,
   output logic busy_o,
   output logic done_o,
   output logic err_o,
   output logic capture_o
);

   dp_mem_state_t state_q, state_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic          timeout;

`ifdef DATAPATH_BUS_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   // Counter runs only in REQ, so it is always zero on entry to REQ.
   assign cnt_d   = (state_q == ST_REQ) ? cnt_q + 8'd1 : 8'd0;
   assign timeout = (cnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) cnt_q <= 8'd0;
      else      cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (mem_rd_i ^ mem_wr_i) begin
               state_d = ST_REQ;
               we_d    = mem_wr_i;
            end else if (mem_rd_i && mem_wr_i) begin
               err_d = 1'b1;
            end
         end
         ST_REQ: begin
            err_d = mem_rd_i | mem_wr_i;
            if (mem_ack_i) begin
               state_d = ST_DONE;
            end else if (timeout) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_DONE: begin
            err_d   = mem_rd_i | mem_wr_i;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_req_o = (state_q == ST_REQ);
   assign mem_we_o  = we_q;
   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = (state_q == ST_DONE);
   assign err_o     = err_q;
   assign capture_o = (state_q == ST_REQ) && mem_ack_i && !we_q;

endmodule

// File: rtl/datapath_bus_core.sv
// Parametrised datapath: register file, A/B buses, NZVC PSW, MAR/MDR and memory handshake.
// Optional REQ timeout enabled by DATAPATH_BUS_TIMEOUT_EN (implemented in dp_mem_fsm).
module datapath_bus_core
   import dp_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NREG    = 8,
   parameter int PSW_IDX = 5,
   parameter int TIMEOUT = 15
) (
   input  logic                    CLK,
   input  logic                    CLR,
   input  logic                    a_en,
   input  logic [$clog2(NREG)-1:0] a_sel,
   input  logic                    a_mdr,
   input  logic                    b_en,
   input  logic [WIDTH-1:0]        s_in,
   input  logic                    reg_we,
   input  logic [$clog2(NREG)-1:0] reg_wsel,
   input  logic                    b0_we,
   input  logic                    mar_we,
   input  logic                    mdr_we,
   input  logic [3:0]              flag_upd,
   input  logic [3:0]              flag_val,
   input  logic                    psw_load,
   input  logic                    mem_rd,
   input  logic                    mem_wr,
   output logic [WIDTH-1:0]        a_bus,
   output logic [WIDTH-1:0]        b_bus,
   output logic [3:0]              psw,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [WIDTH-1:0]        mem_addr,
   output logic [WIDTH-1:0]        mem_wdata,
   input  logic [WIDTH-1:0]        mem_rdata,
   input  logic                    mem_ack,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int SELW = $clog2(NREG);

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] reg_wdata;
   logic [WIDTH-1:0] b0_q, mar_q, mdr_q, mdr_d, mar_d;
   logic [3:0]       psw_q, psw_d;
   logic             capture;

   dp_mem_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
      .CLK       (CLK),
      .CLR       (CLR),
      .mem_rd_i  (mem_rd),
      .mem_wr_i  (mem_wr),
      .mem_ack_i (mem_ack),
      .mem_req_o (mem_req),
      .mem_we_o  (mem_we),
      .busy_o    (busy),
      .done_o    (done),
      .err_o     (err),
      .capture_o (capture)
   );

   // The PSW shadow index snapshots the flags instead of taking the S bus.
   assign reg_wdata = (reg_wsel == SELW'(PSW_IDX)) ? {{(WIDTH-4){1'b0}}, psw_q} : s_in;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (reg_we) begin
         regs_q[reg_wsel] <= reg_wdata;
      end
   end

   always_comb begin
      psw_d = psw_q;
      if (psw_load) begin
         psw_d = s_in[FLAG_N:FLAG_C];
      end else begin
         for (int i = 0; i < 4; i++)
            if (flag_upd[i]) psw_d[i] = flag_val[i];
      end
   end

   // Read-data capture outranks mdr_we; both address and data freeze while busy.
   assign mdr_d = capture ? mem_rdata : ((mdr_we && !busy) ? s_in : mdr_q);
   assign mar_d = (mar_we && !busy) ? s_in : mar_q;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         psw_q <= 4'd0;
         b0_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
      end else begin
         psw_q <= psw_d;
         if (b0_we) b0_q <= s_in;
         mar_q <= mar_d;
         mdr_q <= mdr_d;
      end
   end

   assign a_bus     = (a_en ? regs_q[a_sel] : '0) | (a_mdr ? mdr_q : '0);
   assign b_bus     = b_en ? b0_q : '0;
   assign psw       = psw_q;
   assign mem_addr  = mar_q;
   assign mem_wdata = mdr_q;

endmodule
